// File: rtl/puf_seq_pkg.sv
// Shared types and sizing for the arbiter-PUF challenge sequencer.
package puf_seq_pkg;

    localparam int unsigned DEF_SETTLE_CYCLES = 4;
    localparam int unsigned DEF_VOTES         = 5;

    // Counter widths cover the parameter maxima (SETTLE_CYCLES 255, VOTES 15, 8 bits)
    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned VOTE_W   = 4;
    localparam int unsigned BIT_W    = 4;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FIRE  = 3'd2,
        ST_TALLY = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Link between the sequencer and its majority voter.
interface puf_challenge_sequencer_if;

    logic sample;
    logic resp;
    logic clear;
    logic majority;
    logic unanimous;

    modport master (output sample, output resp, output clear, input majority, input unanimous);
    modport slave  (input sample, input resp, input clear, output majority, output unanimous);

endinterface

// File: rtl/puf_majority_voter.sv
// Counts high PUF samples for one bit and decodes majority / unanimity.
module puf_majority_voter
    import puf_seq_pkg::*;
#(
    parameter int unsigned VOTES = DEF_VOTES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    puf_challenge_sequencer_if.slave         vif
);

    logic [VOTE_W-1:0] ones_q;
    logic [VOTE_W-1:0] ones_d;

    // Clear wins over a coincident sample so an aborted vote never leaks
    always_comb begin
        ones_d = ones_q;
        if (vif.clear) begin
            ones_d = '0;
        end else if (vif.sample && vif.resp) begin
            ones_d = ones_q + VOTE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign vif.majority  = (ones_q > VOTE_W'(VOTES / 2));
    assign vif.unanimous = (ones_q == '0) || (ones_q == VOTE_W'(VOTES));

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives challenges and race pulses to an arbiter PUF and majority-votes an 8-bit response.
module puf_challenge_sequencer
    import puf_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned VOTES         = DEF_VOTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [BYTE_W-1:0] chal_seed,
    output logic [BYTE_W-1:0] puf_challenge,
    output logic              puf_pulse,
    input  logic              puf_response,
    output logic              busy,
    output logic [BYTE_W-1:0] resp_byte,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              stable
);

    if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("puf_challenge_sequencer: SETTLE_CYCLES must be 1..255");
    end
    if (VOTES == 0 || VOTES > 15 || (VOTES % 2) == 0) begin : g_bad_votes
        $error("puf_challenge_sequencer: VOTES must be odd and 1..15");
    end

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [VOTE_W-1:0]   vote_q, vote_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [BYTE_W-1:0]   seed_q, seed_d;
    logic [BYTE_W-1:0]   chal_q, chal_d;
    logic [BYTE_W-1:0]   resp_q, resp_d;
    logic                pulse_q, pulse_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                stable_q, stable_d;

    logic last_phase_c;
    logic last_vote_c;
    logic last_bit_c;

    puf_challenge_sequencer_if vote_if ();

    puf_majority_voter #(.VOTES(VOTES)) u_voter (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vote_if.slave)
    );

    assign last_phase_c = (cnt_q == SETTLE_W'(SETTLE_CYCLES - 1));
    assign last_vote_c  = (vote_q == VOTE_W'(VOTES - 1));
    assign last_bit_c   = (bit_q == BIT_W'(7));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; dropping ena anywhere outside IDLE aborts the run
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start && ena) state_d = ST_SETUP;
            ST_SETUP: if (last_phase_c) state_d = ST_FIRE;
            ST_FIRE:  if (last_phase_c) state_d = ST_TALLY;
            ST_TALLY: state_d = (last_vote_c && last_bit_c) ? ST_DONE : ST_SETUP;
            ST_DONE:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !ena) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        cnt_d          = cnt_q;
        vote_d         = vote_q;
        bit_d          = bit_q;
        seed_d         = seed_q;
        chal_d         = chal_q;
        resp_d         = resp_q;
        stable_d       = stable_q;
        vote_if.sample = 1'b0;
        vote_if.resp   = puf_response;
        vote_if.clear  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (state_d == ST_SETUP) begin
                    seed_d        = chal_seed;
                    chal_d        = chal_seed;
                    cnt_d         = '0;
                    vote_d        = '0;
                    bit_d         = '0;
                    resp_d        = '0;
                    stable_d      = 1'b1;
                    vote_if.clear = 1'b1;
                end
            end
            ST_SETUP: begin
                cnt_d = last_phase_c ? '0 : cnt_q + SETTLE_W'(1);
            end
            ST_FIRE: begin
                cnt_d          = last_phase_c ? '0 : cnt_q + SETTLE_W'(1);
                vote_if.sample = last_phase_c;
            end
            ST_TALLY: begin
                cnt_d = '0;
                if (last_vote_c) begin
                    vote_d                 = '0;
                    resp_d[bit_q[2:0]]     = vote_if.majority;
                    stable_d               = stable_q & vote_if.unanimous;
                    vote_if.clear          = 1'b1;
                    bit_d                  = bit_q + BIT_W'(1);
                    if (!last_bit_c) begin
                        chal_d = seed_q + BYTE_W'(bit_d);
                    end
                end else begin
                    vote_d = vote_q + VOTE_W'(1);
                end
            end
            ST_DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        // Abort keeps the last published byte/stable and restarts the counters
        if (state_q != ST_IDLE && !ena) begin
            resp_d        = resp_q;
            stable_d      = stable_q;
            cnt_d         = '0;
            vote_d        = '0;
            bit_d         = '0;
            vote_if.clear = 1'b1;
        end
    end

    // Registered outputs are decoded from the next state so they align with it
    always_comb begin
        pulse_d = (state_d == ST_FIRE);
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            vote_q   <= '0;
            bit_q    <= '0;
            seed_q   <= '0;
            chal_q   <= '0;
            resp_q   <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            vote_q   <= vote_d;
            bit_q    <= bit_d;
            seed_q   <= seed_d;
            chal_q   <= chal_d;
            resp_q   <= resp_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            stable_q <= stable_d;
        end
    end

    assign puf_challenge = chal_q;
    assign puf_pulse     = pulse_q;
    assign busy          = busy_q;
    assign resp_byte     = resp_q;
    assign resp_valid    = valid_q;
    assign stable        = stable_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with a behavioural PUF and pulse/challenge monitor.
module tb_puf_challenge_sequencer;

    localparam int S = 4;
    localparam int V = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] chal_seed;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic       puf_response;
    logic       busy;
    logic [7:0] resp_byte;
    logic       resp_valid;
    logic       resp_ready;
    logic       stable;

    int vectors = 0;
    int errors  = 0;

    int         mode        = 0;
    int         pulse_total = 0;
    int         run_len     = 0;
    logic       pulse_prev  = 1'b0;
    logic       busy_prev   = 1'b0;
    logic [7:0] chal_rise   = 8'h00;
    logic [7:0] seed_cur    = 8'h00;
    bit         valid_seen  = 1'b0;

    always #5 clk = ~clk;

    puf_challenge_sequencer #(.SETTLE_CYCLES(S), .VOTES(V)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .start         (start),
        .chal_seed     (chal_seed),
        .puf_challenge (puf_challenge),
        .puf_pulse     (puf_pulse),
        .puf_response  (puf_response),
        .busy          (busy),
        .resp_byte     (resp_byte),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .stable        (stable)
    );

    // PUF model: vote index within a bit is the count of finished pulses mod V
    always_comb begin
        case (mode)
            0:       puf_response = 1'b1;
            1:       puf_response = puf_challenge[0];
            2:       puf_response = ((pulse_total % V) < 3);
            3:       puf_response = ((pulse_total % V) < 2);
            default: puf_response = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse width, challenge sequence and challenge hold while pulsing
    always @(negedge clk) begin
        if (busy && !busy_prev) pulse_total = 0;
        if (puf_pulse) begin
            if (!pulse_prev) begin
                run_len   = 1;
                chal_rise = puf_challenge;
                chk("chal_seq", 32'(puf_challenge), 32'(8'(32'(seed_cur) + pulse_total / V)));
            end else begin
                run_len++;
                chk("chal_hold", 32'(puf_challenge), 32'(chal_rise));
            end
        end else if (pulse_prev) begin
            chk("pulse_len", 32'(run_len), 32'(S));
            pulse_total++;
        end
        if (resp_valid) valid_seen = 1'b1;
        pulse_prev = puf_pulse;
        busy_prev  = busy;
    end

    task automatic kick(input logic [7:0] s);
        @(negedge clk);
        seed_cur  = s;
        chal_seed = s;
        ena       = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("hs_busy", 32'(busy), 32'(0));
        chk("hs_valid", 32'(resp_valid), 32'(0));
    endtask

    task automatic full_run(input int m, input logic [7:0] s, input logic [7:0] exp_byte,
                            input logic exp_stable, input string tag);
        int n;
        mode = m;
        kick(s);
        wait_valid(n);
        chk({tag, "_latency"}, 32'(n), 32'(360));
        chk({tag, "_byte"}, 32'(resp_byte), 32'(exp_byte));
        chk({tag, "_stable"}, 32'(stable), 32'(exp_stable));
        chk({tag, "_busy"}, 32'(busy), 32'(1));
        chk({tag, "_pulses"}, 32'(pulse_total), 32'(40));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; resp_ready = 1'b0; chal_seed = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_pulse", 32'(puf_pulse), 32'(0));
        chk("rst_valid", 32'(resp_valid), 32'(0));
        chk("rst_byte", 32'(resp_byte), 32'(0));
        chk("rst_stable", 32'(stable), 32'(0));
        chk("rst_chal", 32'(puf_challenge), 32'(0));
        @(negedge clk) rst_n = 1'b1;

        // start without ena is not accepted
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("noena_busy", 32'(busy), 32'(0));

        full_run(0, 8'h00, 8'hFF, 1'b1, "ones");
        handshake();
        full_run(1, 8'h10, 8'hAA, 1'b1, "chal0");
        handshake();
        full_run(2, 8'h33, 8'hFF, 1'b0, "maj3of5");
        handshake();
        full_run(3, 8'hF8, 8'h00, 1'b0, "maj2of5");
        handshake();

        // Back-pressure: valid/byte held, start ignored while DONE
        full_run(0, 8'h5A, 8'hFF, 1'b1, "hold");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start     = (c == 10);
            chal_seed = 8'hC3;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(resp_valid), 32'(1));
            chk("hold_byte", 32'(resp_byte), 32'(8'hFF));
            chk("hold_stable", 32'(stable), 32'(1));
        end
        @(negedge clk);
        start      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        resp_ready = 1'b0;
        chk("hs_start_busy", 32'(busy), 32'(0));
        chk("hs_start_valid", 32'(resp_valid), 32'(0));
        @(posedge clk);
        #1 chk("hs_start_idle", 32'(busy), 32'(0));

        // ena dropped at cycle 100: two bits finished, third in progress
        mode = 0;
        kick(8'h00);
        repeat (99) @(posedge clk);
        #1 ena = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pulse", 32'(puf_pulse), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_valid", 32'(resp_valid), 32'(0));
        chk("abort_byte", 32'(resp_byte), 32'(8'h03));
        chk("abort_stable", 32'(stable), 32'(1));
        ena        = 1'b1;
        valid_seen = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        chk("abort_novalid", 32'(valid_seen), 32'(0));
        chk("abort_idle", 32'(busy), 32'(0));

        // rst_n pulsed at cycle 100
        kick(8'h77);
        repeat (99) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_pulse", 32'(puf_pulse), 32'(0));
        chk("mrst_busy", 32'(busy), 32'(0));
        chk("mrst_valid", 32'(resp_valid), 32'(0));
        chk("mrst_byte", 32'(resp_byte), 32'(0));
        chk("mrst_stable", 32'(stable), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        valid_seen = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        chk("mrst_novalid", 32'(valid_seen), 32'(0));
        chk("mrst_idle", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
